// File: rtl/button_debouncer.sv
// button_debouncer
//   Turns one raw, bouncing, asynchronous push-button level into a clean,
//   glitch-free level in the clk domain. The raw input first passes through a
//   two-flop synchronizer. The output changes only after the synchronized level
//   has held its new value for STABLE_CYCLES consecutive clocks.
//
// Ports
//   clk    in   system clock; all state updates on the rising edge
//   reset  in   asynchronous reset, active low (0 = in reset)
//   BTN    in   raw button level, asynchronous to clk, may bounce
//   clean  out  debounced button level, driven straight from a flop
module button_debouncer #(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic BTN,
  output logic clean
);

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,  // clean = 0, input stable low
    S_RISE = 2'b01,  // clean = 0, counting a candidate high
    S_HIGH = 2'b10,  // clean = 1, input stable high
    S_FALL = 2'b11   // clean = 1, counting a candidate low
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             clean_q, clean_d;

  always_comb begin
    sync1_d = BTN;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;

    // The counter counts only while a candidate level is present; reaching
    // STABLE_CYCLES-1 commits the level, so it can never wrap.
    case (state_q)
      S_LOW: begin
        clean_d = 1'b0;
        if (sync2_q) begin
          state_d = S_RISE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      S_RISE: begin
        clean_d = 1'b0;
        if (!sync2_q) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          clean_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        clean_d = 1'b1;
        if (!sync2_q) begin
          state_d = S_FALL;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      S_FALL: begin
        clean_d = 1'b1;
        if (sync2_q) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          clean_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        // Corrupted state register: fall back to a known-quiet state.
        state_d = S_LOW;
        clean_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= S_LOW;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean = clean_q;

endmodule

// File: tb/tb_button_debouncer.sv
`timescale 1ns/100ps
module tb_button_debouncer;

  localparam int SA = 8;
  localparam int SB = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic BTN   = 1'b0;
  logic clean_a;
  logic clean_b;

  int tests = 0;
  int fails = 0;

  always #1 clk = ~clk;

  button_debouncer #(.STABLE_CYCLES(SA)) dut_a (
    .clk(clk), .reset(reset), .BTN(BTN), .clean(clean_a)
  );
  button_debouncer #(.STABLE_CYCLES(SB)) dut_b (
    .clk(clk), .reset(reset), .BTN(BTN), .clean(clean_b)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: h[0] is the BTN level sampled at the previous edge,
  // h[i] the one sampled i edges earlier. The output seen at an edge is
  // decided by the samples two or more edges old (two sync stages): if the
  // last S of those all differ from the current output, the output flips.
  // Reset clears history to 0, matching cleared synchronizer flops.
  bit ha [0:SA];
  bit hb [0:SB];
  bit ma, mb;

  always @(posedge clk or negedge reset) begin
    bit all;
    if (!reset) begin
      for (int i = 0; i <= SA; i++) ha[i] = 1'b0;
      for (int i = 0; i <= SB; i++) hb[i] = 1'b0;
      ma = 1'b0;
      mb = 1'b0;
    end else begin
      all = 1'b1;
      for (int i = 1; i <= SA; i++) if (ha[i] == ma) all = 1'b0;
      if (all) ma = ~ma;
      for (int i = SA; i > 0; i--) ha[i] = ha[i-1];
      ha[0] = BTN;

      all = 1'b1;
      for (int i = 1; i <= SB; i++) if (hb[i] == mb) all = 1'b0;
      if (all) mb = ~mb;
      for (int i = SB; i > 0; i--) hb[i] = hb[i-1];
      hb[0] = BTN;
    end
  end

  // Every cycle, shortly after the falling edge (after stimulus has settled).
  always @(negedge clk) begin
    #0.2;
    check("model_a", int'(clean_a), int'(ma));
    check("model_b", int'(clean_b), int'(mb));
  end

  initial begin
    bit b_rose;
    bit a_moved;
    int runlen;

    // 1: reset held, BTN toggling every 10 clocks -> clean stays 0.
    a_moved = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (t % 10 == 0) BTN = ~BTN;
      #0.1;
      if (clean_a !== 1'b0 || clean_b !== 1'b0) a_moved = 1'b1;
    end
    check("reset_hold_clean", int'(a_moved), 0);

    // 2: release, then BTN 0->1 -> clean rises exactly 9 edges later.
    @(negedge clk); BTN = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    BTN = 1'b1;
    @(negedge clk);                       // edge k sampled BTN=1
    repeat (8) @(negedge clk);            // edges k+1..k+8
    #0.1 check("rise_not_early", int'(clean_a), 0);
    @(negedge clk);                       // edge k+9
    #0.1 check("rise_at_k9", int'(clean_a), 1);
    repeat (10) @(negedge clk);
    #0.1 check("rise_holds", int'(clean_a), 1);

    // 3: short low pulse (5 clocks) is ignored.
    BTN = 1'b0;
    repeat (5) @(negedge clk);
    BTN = 1'b1;
    a_moved = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      #0.1 if (clean_a !== 1'b1) a_moved = 1'b1;
    end
    check("short_low_ignored", int'(a_moved), 0);
    // Back in stable high: a full low run is needed again to fall.
    BTN = 1'b0;
    repeat (9) @(negedge clk);
    #0.1 check("fall_not_early", int'(clean_a), 1);
    @(negedge clk);
    #0.1 check("fall_at_k9", int'(clean_a), 0);

    // 4: toggle every 10 clocks; S=8 follows, S=16 never moves.
    repeat (30) @(negedge clk);
    b_rose = 1'b0;
    for (int p = 0; p < 8; p++) begin
      BTN = ~BTN;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        #0.1 if (clean_b !== 1'b0) b_rose = 1'b1;
      end
      if (p == 0) check("toggle_first_rise", int'(clean_a), 1);
    end
    check("toggle_s16_stays_low", int'(b_rose), 0);

    // 5: reset asserted mid-count, then a full count after release.
    BTN = 1'b0;
    repeat (20) @(negedge clk);
    BTN = 1'b1;
    repeat (6) @(negedge clk);            // count now 4
    reset = 1'b0;
    #0.1 check("reset_mid_count", int'(clean_a), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);                       // release edge sampled BTN=1
    repeat (8) @(negedge clk);
    #0.1 check("post_reset_not_early", int'(clean_a), 0);
    @(negedge clk);
    #0.1 check("post_reset_rise", int'(clean_a), 1);

    // 6: 1-clock bouncing for 30 clocks, then settle high.
    BTN = 1'b0;
    repeat (20) @(negedge clk);
    #0.1 check("bounce_start_low", int'(clean_a), 0);
    a_moved = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      BTN = ~BTN;
      #0.1 if (clean_a !== 1'b0) a_moved = 1'b1;
    end
    BTN = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      #0.1 if (clean_a !== 1'b0) a_moved = 1'b1;
    end
    check("bounce_no_edge", int'(a_moved), 0);
    repeat (12) @(negedge clk);
    #0.1 check("bounce_settled", int'(clean_a), 1);

    // Random runs with occasional reset pulses, checked by the model.
    for (int r = 0; r < 200; r++) begin
      @(negedge clk);
      BTN = ~BTN;
      if ($urandom_range(0, 2) == 0) runlen = $urandom_range(8, 30);
      else runlen = $urandom_range(1, 10);
      if ($urandom_range(0, 40) == 0) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b1;
      end
      repeat (runlen - 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    #0.5;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
